mul_add_16bit: RTL and testbench
================================

# mul_add_16bit

Sequential 16x16 unsigned multiply-add engine that computes `product = A * B + C` by radix-2 shift-add over 16 clock cycles. It is the reconstruction direction of the arithmetic library's 16-bit divider: feeding it a quotient, divisor and remainder returns the original dividend. It is used both as a datapath multiplier and as the self-check stage behind division results. A start/busy/done handshake lets a controller launch one operation at a time.

## Interface
- No parameters; widths fixed at 16-bit operands and a 32-bit result.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; sampled on rising edge.
- `A`  in  16  multiplicand, unsigned; captured on accepted start.
- `B`  in  16  multiplier, unsigned; captured on accepted start.
- `C`  in  16  addend, unsigned, zero-extended to 32 bits; captured on accepted start.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when `product` updates.
- `product`  out  32  result `A*B + C`; held until the next completion.

## Operation
- States:
  - IDLE (reset state).
  - CALC: 16 iterations, bit counter 0..15.
  - DONE: one cycle.
- IDLE, `start`=1: capture `A`, `B`, `C`; accumulator = `{16'd0, C}`; counter = 0; go to CALC.
- CALC, each cycle i (0..15):
  - If captured `B[i]`=1, add `{16'd0, A} << i` to the accumulator (32-bit add).
  - Counter increments.
  - After i=15, load `product` from the final accumulator and go to DONE.
- DONE: `done`=1 for this cycle only.
  - If `start`=1 here, it is accepted exactly as in IDLE and the next state is CALC.
  - Otherwise the next state is IDLE.
- `start` while in CALC is ignored; it is neither queued nor captured.
- Changes on `A`/`B`/`C` after capture do not affect the operation in flight.
- Width rule: the maximum result is 0xFFFF*0xFFFF + 0xFFFF = 0xFFFF0000, so the 32-bit accumulator never overflows and there is no carry-out.
- A=0 or B=0 yields `product` = C; all 16 iterations still run, with no early termination.

## Timing
- Reset values (asynchronous assert, takes effect immediately):
  - state = IDLE, `busy`=0, `done`=0, `product`=0.
  - Accumulator, counter and captured operands = 0.
- Reset mid-operation aborts the operation with no `done` pulse; `product` reads 0 after reset.
- Reset release: the first accepted `start` is on the first rising edge with `rst_n`=1.
- Latency for `start` accepted at edge E:
  - `busy`=1 from E through E+16.
  - At E+17: `product` valid, `done`=1, `busy`=0.
  - Edge count from accept to result is 17.
- `done` and `busy` are never high in the same cycle.
- Back-to-back: a `start` held high through DONE is accepted at E+17, giving one result every 17 cycles. `product` from the first operation stays valid until E+34.
- `product` changes only at the DONE transition, never during CALC.

## Test plan
- Basic: A=0x1234, B=0x5678, C=0 -> `product`=0x06260060; `done` pulses exactly 17 edges after start, one cycle wide.
- Extremes: A=0xFFFF, B=0xFFFF, C=0xFFFF -> 0xFFFF0000. A=0, B=0xABCD, C=0x1357 -> 0x00001357.
- Divider round trip: A=0x000E, B=0x0007, C=0x0002 -> 0x00000064. Also a random sweep of (Q, D, R) from the divider, checking the dividend is reconstructed.
- Busy ignore: pulse `start` at cycles 5 and 10 of CALC with different operands -> single `done`, result of the first operands only.
- Back-to-back: hold `start` high with A=3, B=5, C=1 then A=2, B=2, C=0 -> `done` at E+17 (0x10) and E+34 (0x4). `product` holds 0x10 between the two pulses.
- Reset mid-op: assert `rst_n`=0 at CALC cycle 8 -> `busy`, `done` and `product` go to 0 immediately, no `done` pulse. A new start after release gives the correct result.

Source files
------------

// File: rtl/mul_add_16bit.sv
// mul_add_16bit: sequential 16x16 unsigned multiply-add, product = A*B + C.
// Radix-2 shift-add over 16 cycles. It also rebuilds a dividend from
// (quotient, divisor, remainder) produced by the 16-bit divider.
//
// Handshake (start/busy/done):
//   - start is sampled on a rising edge. It is accepted when the engine is
//     IDLE or DONE. A, B and C are captured on that same edge.
//   - busy is high for the 16 CALC cycles that follow the accepting edge.
//     A start seen while busy is dropped. It is neither queued nor captured.
//   - done is high for exactly one cycle. In that cycle product holds the
//     new result. product then stays unchanged until the next completion.
//   - busy and done are never high together.
//   - A controller that holds start high through DONE gets one result every
//     17 edges.
module mul_add_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] C,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] product_q, product_d;

  logic        accept;
  logic        last_iter;
  logic [31:0] partial;
  logic [31:0] acc_sum;

  // A new operation is taken only from IDLE or from the single DONE cycle.
  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_iter = (cnt_q == 4'd15);

  // Shift-add step: add A shifted by the bit index when that bit of B is set.
  // The worst case is 0xFFFF*0xFFFF + 0xFFFF = 0xFFFF0000, so the
  // accumulator cannot carry out of 32 bits.
  always_comb begin
    partial = 32'd0;
    if (b_q[cnt_q]) begin
      partial = {16'd0, a_q} << cnt_q;
    end
    acc_sum = acc_q + partial;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = start ? S_CALC : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs: busy, done and the debug state are direct decodes of the state.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    dbg_state = state_q;
    unique case (state_q)
      S_CALC:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next-state logic.
  //   - On accept: capture the operands and seed the accumulator with C.
  //   - In CALC: do one shift-add step per cycle.
  //   - On the last step: also publish the final sum to product.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (accept) begin
      a_d   = A;
      b_d   = B;
      acc_d = {16'd0, C};
      cnt_d = 4'd0;
    end else if (state_q == S_CALC) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + 4'd1;
      if (last_iter) begin
        product_d = acc_sum;
      end
    end
  end

  // Datapath registers. Reset clears everything, which aborts any operation
  // in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 4'd0;
      a_q       <= 16'd0;
      b_q       <= 16'd0;
      acc_q     <= 32'd0;
      product_q <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

  // busy and done decode disjoint states, so they must never overlap.
  a_busy_done_exclusive: assert property (
    @(posedge clk) disable iff (!rst_n) !(busy && done)
  );

endmodule

// File: tb/tb_mul_add_16bit.sv
// Self-checking bench for mul_add_16bit.
// The reference model is plain arithmetic: A*B + C in 32 bits.
module tb_mul_add_16bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] C;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  mul_add_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .C         (C),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .dbg_state (dbg_state)
  );

  // Clock / reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model.
  function automatic logic [31:0] model(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic [15:0] c);
    longint unsigned r;
    r = longint'(a) * longint'(b) + longint'(c);
    return r[31:0];
  endfunction

  // Driver tasks.

  // launch: called at a negedge.
  //   - Drives start with the operands.
  //   - Lets the next rising edge (E) accept them.
  //   - Drops start and scrambles the operand inputs at the following negedge.
  task automatic launch(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [15:0] c);
    A     = a;
    B     = b;
    C     = c;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A     = 16'($urandom);
    B     = 16'($urandom);
    C     = 16'($urandom);
  endtask

  // wait_result: called at the negedge just before edge E+1.
  //   - lat is n when done is first seen at the negedge before edge E+n.
  //   - lat is 0 if done never shows up within the 40-cycle bound.
  //   - busy_err counts cycles before done in which busy was low.
  task automatic wait_result(output logic [31:0] prod,
                             output int lat,
                             output int busy_err);
    lat      = 0;
    busy_err = 0;
    prod     = 32'd0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (done) begin
        lat  = n;
        prod = product;
        break;
      end
      if (!busy) busy_err++;
    end
  endtask

  task automatic do_op(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [15:0] c,
                       output logic [31:0] prod,
                       output int lat,
                       output int busy_err);
    @(negedge clk);
    launch(a, b, c);
    wait_result(prod, lat, busy_err);
  endtask

  // Tests.

  task automatic test_reset();
    logic [31:0] prod;
    int lat;
    int berr;
    rst_n = 1'b0;
    start = 1'b0;
    A = 16'd0; B = 16'd0; C = 16'd0;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
      failures++;
      $display("FAIL reset_async busy=%b done=%b product=%h required 0/0/0",
               busy, done, product);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_held busy=%b done=%b product=%h state=%0d required 0/0/0/0",
               busy, done, product, dbg_state);
    end
    // Release reset and launch in the same cycle: the first rising edge with
    // rst_n high must accept the start.
    rst_n = 1'b1;
    launch(16'd7, 16'd9, 16'd5);
    wait_result(prod, lat, berr);
    checks++;
    if (lat !== 17 || prod !== 32'd68 || berr !== 0) begin
      failures++;
      $display("FAIL first_start_after_reset lat=%0d product=%h busy_err=%0d required 17/%h/0",
               lat, prod, berr, 32'd68);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va[5];
    logic [15:0] vb[5];
    logic [15:0] vc[5];
    logic [31:0] vp[5];
    logic [31:0] prod;
    int lat;
    int berr;
    va = '{16'h1234, 16'hFFFF, 16'h0000, 16'h000E, 16'hABCD};
    vb = '{16'h5678, 16'hFFFF, 16'hABCD, 16'h0007, 16'h0000};
    vc = '{16'h0000, 16'hFFFF, 16'h1357, 16'h0002, 16'h00FF};
    vp = '{32'h06260060, 32'hFFFF0000, 32'h00001357, 32'h00000064, 32'h000000FF};
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vc[i], prod, lat, berr);
      checks++;
      if (prod !== vp[i]) begin
        failures++;
        $display("FAIL directed_%0d product=%h required %h", i, prod, vp[i]);
      end
      checks++;
      if (lat !== 17 || berr !== 0) begin
        failures++;
        $display("FAIL directed_latency_%0d lat=%0d busy_err=%0d required 17/0", i, lat, berr);
      end
      // done must be a single-cycle pulse, and product must hold afterwards.
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== vp[i]) begin
        failures++;
        $display("FAIL directed_pulse_%0d done=%b busy=%b product=%h required 0/0/%h",
                 i, done, busy, product, vp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] prod;
    logic [31:0] exp;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    int lat;
    int berr;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 16'($urandom);
      if (i == 0) a = 16'hFFFF;
      exp_q.push_back(model(a, b, c));
      do_op(a, b, c, prod, lat, berr);
      exp = exp_q.pop_front();
      checks++;
      if (prod !== exp || lat !== 17) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h c=%h product=%h lat=%0d required %h/17",
                 i, a, b, c, prod, lat, exp);
      end
    end
  endtask

  task automatic test_divider_roundtrip();
    logic [31:0] prod;
    longint unsigned n;
    longint unsigned d;
    logic [15:0] q;
    logic [15:0] r;
    int lat;
    int berr;
    for (int i = 0; i < 12; i++) begin
      d = longint'($urandom_range(65535, 1));
      n = longint'($urandom) % (d << 16);
      q = 16'(n / d);
      r = 16'(n % d);
      do_op(q, 16'(d), r, prod, lat, berr);
      checks++;
      if (prod !== 32'(n)) begin
        failures++;
        $display("FAIL roundtrip_%0d q=%h d=%h r=%h product=%h required %h",
                 i, q, 16'(d), r, prod, 32'(n));
      end
    end
  endtask

  task automatic test_busy_ignore();
    int done_cnt;
    int first_lat;
    logic [31:0] first_prod;
    logic [31:0] exp;
    exp = model(16'h0123, 16'h0456, 16'h0789);
    done_cnt   = 0;
    first_lat  = 0;
    first_prod = 32'd0;
    @(negedge clk);
    launch(16'h0123, 16'h0456, 16'h0789);
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 5 || n == 10) begin
        A = 16'hFFFF; B = 16'hFFFF; C = 16'h1111; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (first_lat == 0) begin
          first_lat  = n;
          first_prod = product;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (done_cnt !== 1 || first_lat !== 17 || first_prod !== exp) begin
      failures++;
      $display("FAIL busy_ignore dones=%0d lat=%0d product=%h required 1/17/%h",
               done_cnt, first_lat, first_prod, exp);
    end
  endtask

  task automatic test_back_to_back();
    int dn[$];
    logic [31:0] dp[$];
    int hold_err;
    hold_err = 0;
    @(negedge clk);
    A = 16'd3; B = 16'd5; C = 16'd1; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        A = 16'd2; B = 16'd2; C = 16'd0;
      end
      if (n == 18) start = 1'b0;
      if (done) begin
        dn.push_back(n);
        dp.push_back(product);
      end
      if (n > 17 && n < 34 && product !== 32'h10) hold_err++;
    end
    start = 1'b0;
    checks++;
    if (dn.size() != 2) begin
      failures++;
      $display("FAIL b2b_count dones=%0d required 2", dn.size());
    end else begin
      checks++;
      if (dn[0] != 17 || dn[1] != 34 || dp[0] !== 32'h10 || dp[1] !== 32'h4) begin
        failures++;
        $display("FAIL b2b_results at=%0d,%0d product=%h,%h required 17,34 00000010,00000004",
                 dn[0], dn[1], dp[0], dp[1]);
      end
    end
    checks++;
    if (hold_err != 0) begin
      failures++;
      $display("FAIL b2b_hold changed_cycles=%0d required 0", hold_err);
    end
  endtask

  task automatic test_reset_midop();
    int done_cnt;
    logic [31:0] prod;
    int lat;
    int berr;
    done_cnt = 0;
    @(negedge clk);
    launch(16'h8001, 16'hC003, 16'h0042);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
      failures++;
      $display("FAIL reset_midop busy=%b done=%b product=%h required 0/0/0",
               busy, done, product);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checks++;
    if (done_cnt != 0 || product !== 32'd0) begin
      failures++;
      $display("FAIL reset_midop_no_done dones=%0d product=%h required 0/0", done_cnt, product);
    end
    do_op(16'h8001, 16'hC003, 16'h0042, prod, lat, berr);
    checks++;
    if (prod !== model(16'h8001, 16'hC003, 16'h0042) || lat !== 17) begin
      failures++;
      $display("FAIL reset_midop_recover product=%h lat=%0d required %h/17",
               prod, lat, model(16'h8001, 16'hC003, 16'h0042));
    end
  endtask

  // Sequencer and final report.
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_divider_roundtrip();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout simulation exceeded bound");
    $fatal(1);
  end

endmodule
